// File: rtl/ysyx_22040386_lsu_pkg.sv
// Shared types and codes for the MEM-stage load/store unit.
// Imported by the LSU top and its lane-alignment helper.
package ysyx_22040386_lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_RSP,
      S_DONE
   } lsu_state_e;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam logic [3:0] CAUSE_LD_MIS = 4'd4;
   localparam logic [3:0] CAUSE_LD_ACC = 4'd5;
   localparam logic [3:0] CAUSE_ST_MIS = 4'd6;
   localparam logic [3:0] CAUSE_ST_ACC = 4'd7;

   function automatic logic [3:0] lsu_cause(
      input logic we,
      input logic acc
   );
      logic [3:0] c;
      unique case ({we, acc})
         2'b00:   c = CAUSE_LD_MIS;
         2'b01:   c = CAUSE_LD_ACC;
         2'b10:   c = CAUSE_ST_MIS;
         default: c = CAUSE_ST_ACC;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/ysyx_22040386_lsu_align.sv
// Combinational lane logic: misalign/illegal checks, store
// strobe and data shift, load lane extract and extension.
module ysyx_22040386_lsu_align
   import ysyx_22040386_lsu_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [2:0]          funct3,
   input  logic [2:0]          addr_lo,
   input  logic                we,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W-1:0]   rsp_data,
   output logic                misalign,
   output logic                illegal,
   output logic [DATA_W/8-1:0] wstrb,
   output logic [DATA_W-1:0]   wdata_sh,
   output logic [DATA_W-1:0]   rdata
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam logic XLEN32 = (DATA_W == 32);

   logic [OFF_W-1:0]         off;
   logic [OFF_W+2:0]         bsh;
   logic [1:0]               size;
   logic [STRB_W-1:0]        base;
   logic [6:0]               sa;
   logic [DATA_W-1:0]        sh;
   logic [DATA_W-1:0]        tmp;

   assign off  = addr_lo[OFF_W-1:0];
   assign bsh  = {off, 3'b000};
   assign size = funct3[1:0];

   // Doublewords and lwu only exist on a 64-bit datapath.
   assign illegal = (XLEN32 & ((size == SZ_D) |
                               (funct3 == 3'b110)))
                  | (funct3 == 3'b111);

   always_comb begin
      base     = '0;
      sa       = '0;
      misalign = 1'b0;
      unique case (size)
         SZ_B: begin
            base = STRB_W'(8'h01);
            sa   = 7'(DATA_W - 8);
         end
         SZ_H: begin
            base     = STRB_W'(8'h03);
            sa       = 7'(DATA_W - 16);
            misalign = addr_lo[0];
         end
         SZ_W: begin
            base     = STRB_W'(8'h0F);
            sa       = 7'(DATA_W - 32);
            misalign = |addr_lo[1:0];
         end
         default: begin
            base     = STRB_W'(8'hFF);
            sa       = '0;
            misalign = |addr_lo;
         end
      endcase

      wstrb    = we ? (base << off) : '0;
      wdata_sh = we ? (wdata << bsh) : '0;

      // Move the lane to bit 0, then push it to the top and
      // back down so the shift itself does the extension.
      sh  = rsp_data >> bsh;
      tmp = sh << sa;
      if (funct3[2])
         rdata = tmp >> sa;
      else
         rdata = $signed(tmp) >>> sa;
   end

endmodule

// File: rtl/ysyx_22040386_lsu.sv
// MEM-stage load/store unit: bus handshake FSM, capture regs,
// kill flag and response timeout around the lane helper.
module ysyx_22040386_lsu
   import ysyx_22040386_lsu_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int ADDR_W  = 64,
   parameter int TIMEOUT = 255
) (
   input  logic                i_LSU_clk,
   input  logic                i_LSU_rst,
   input  logic                i_LSU_valid,
   input  logic                i_LSU_load,
   input  logic                i_LSU_store,
   input  logic [2:0]          i_LSU_funct3,
   input  logic [ADDR_W-1:0]   i_LSU_addr,
   input  logic [DATA_W-1:0]   i_LSU_wdata,
   input  logic                i_LSU_flush,
   output logic                o_LSU_stall,
   output logic                o_LSU_done,
   output logic [DATA_W-1:0]   o_LSU_rdata,
   output logic                o_LSU_rf_wen,
   output logic                o_LSU_fault,
   output logic [3:0]          o_LSU_cause,
   output logic                o_LSU_req_valid,
   input  logic                i_LSU_req_ready,
   output logic                o_LSU_req_we,
   output logic [ADDR_W-1:0]   o_LSU_req_addr,
   output logic [DATA_W-1:0]   o_LSU_req_wdata,
   output logic [DATA_W/8-1:0] o_LSU_req_wstrb,
   input  logic                i_LSU_rsp_valid,
   input  logic [DATA_W-1:0]   i_LSU_rsp_data,
   input  logic                i_LSU_rsp_err
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int CNT_W  = (TIMEOUT < 2) ? 1
                         : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic TO_EN = (TIMEOUT != 0);

   lsu_state_e          state;
   logic [ADDR_W-1:0]   addr_q;
   logic [2:0]          f3_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                we_q;
   logic                kill_q;
   logic                fault_q;
   logic [3:0]          cause_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [CNT_W-1:0]    cnt_q;

   logic                idle;
   logic                access;
   logic                start;
   logic [2:0]          a_f3;
   logic [2:0]          a_lo;
   logic                a_we;
   logic                a_mis;
   logic                a_ill;
   logic [STRB_W-1:0]   a_wstrb;
   logic [DATA_W-1:0]   a_wdata;
   logic [DATA_W-1:0]   a_rdata;

   assign idle   = (state == S_IDLE);
   assign access = i_LSU_valid & (i_LSU_load | i_LSU_store);
   assign start  = idle & access & ~i_LSU_flush;

   // Idle checks the incoming op; later states use captured ones.
   assign a_f3 = idle ? i_LSU_funct3     : f3_q;
   assign a_lo = idle ? i_LSU_addr[2:0]  : addr_q[2:0];
   assign a_we = idle ? i_LSU_store      : we_q;

   ysyx_22040386_lsu_align #(
      .DATA_W (DATA_W)
   ) u_align (
      .funct3   (a_f3),
      .addr_lo  (a_lo),
      .we       (a_we),
      .wdata    (wdata_q),
      .rsp_data (i_LSU_rsp_data),
      .misalign (a_mis),
      .illegal  (a_ill),
      .wstrb    (a_wstrb),
      .wdata_sh (a_wdata),
      .rdata    (a_rdata)
   );

   assign o_LSU_stall = start
                      | (state == S_REQ)
                      | (state == S_RSP);
   assign o_LSU_done      = (state == S_DONE);
   assign o_LSU_req_valid = (state == S_REQ);
   assign o_LSU_req_we    = o_LSU_req_valid & we_q;
   assign o_LSU_req_addr  = o_LSU_req_valid
                          ? {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)}
                          : '0;
   assign o_LSU_req_wstrb = o_LSU_req_valid ? a_wstrb : '0;
   assign o_LSU_req_wdata = o_LSU_req_valid ? a_wdata : '0;
   assign o_LSU_fault  = o_LSU_done & fault_q & ~kill_q;
   assign o_LSU_cause  = o_LSU_fault ? cause_q : '0;
   assign o_LSU_rf_wen = o_LSU_done & ~we_q
                       & ~fault_q & ~kill_q;
   assign o_LSU_rdata  = rdata_q;

   always_ff @(posedge i_LSU_clk) begin
      if (i_LSU_rst) begin
         state   <= S_IDLE;
         addr_q  <= '0;
         f3_q    <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         kill_q  <= 1'b0;
         fault_q <= 1'b0;
         cause_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  addr_q  <= i_LSU_addr;
                  f3_q    <= i_LSU_funct3;
                  wdata_q <= i_LSU_wdata;
                  we_q    <= i_LSU_store;
                  kill_q  <= 1'b0;
                  fault_q <= 1'b0;
                  cause_q <= '0;
                  cnt_q   <= '0;
                  if (a_mis) begin
                     state   <= S_DONE;
                     fault_q <= 1'b1;
                     cause_q <= lsu_cause(i_LSU_store, 1'b0);
                  end else if (a_ill) begin
                     state   <= S_DONE;
                     fault_q <= 1'b1;
                     cause_q <= lsu_cause(i_LSU_store, 1'b1);
                  end else begin
                     state <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (i_LSU_flush)
                  kill_q <= 1'b1;
               if (i_LSU_req_ready) begin
                  state <= S_RSP;
                  cnt_q <= '0;
               end
            end
            S_RSP: begin
               if (i_LSU_flush)
                  kill_q <= 1'b1;
               // A response in the timeout cycle still wins.
               if (i_LSU_rsp_valid) begin
                  state <= S_DONE;
                  if (i_LSU_rsp_err) begin
                     fault_q <= 1'b1;
                     cause_q <= lsu_cause(we_q, 1'b1);
                  end else if (!we_q) begin
                     rdata_q <= a_rdata;
                  end
               end else if (TO_EN && cnt_q == CNT_TO) begin
                  state   <= S_DONE;
                  fault_q <= 1'b1;
                  cause_q <= lsu_cause(we_q, 1'b1);
               end else if (cnt_q != CNT_MAX) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DONE: begin
               state   <= S_IDLE;
               kill_q  <= 1'b0;
               fault_q <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22040386_lsu.sv
// Directed bench for the LSU: vector table of single accesses
// plus hand sequences for timeout, flush and reset corners.
module tb_ysyx_22040386_lsu;

   localparam int DW = 64;
   localparam int AW = 64;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid, load, store, flush;
   logic [2:0]    f3;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          stall, done, rf_wen, fault;
   logic [DW-1:0] rdata;
   logic [3:0]    cause;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [7:0]    req_wstrb;
   logic          rsp_valid, rsp_err;
   logic [DW-1:0] rsp_data;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ysyx_22040386_lsu #(
      .DATA_W (DW), .ADDR_W (AW), .TIMEOUT (TO)
   ) dut (
      .i_LSU_clk       (clk),
      .i_LSU_rst       (rst),
      .i_LSU_valid     (valid),
      .i_LSU_load      (load),
      .i_LSU_store     (store),
      .i_LSU_funct3    (f3),
      .i_LSU_addr      (addr),
      .i_LSU_wdata     (wdata),
      .i_LSU_flush     (flush),
      .o_LSU_stall     (stall),
      .o_LSU_done      (done),
      .o_LSU_rdata     (rdata),
      .o_LSU_rf_wen    (rf_wen),
      .o_LSU_fault     (fault),
      .o_LSU_cause     (cause),
      .o_LSU_req_valid (req_valid),
      .i_LSU_req_ready (req_ready),
      .o_LSU_req_we    (req_we),
      .o_LSU_req_addr  (req_addr),
      .o_LSU_req_wdata (req_wdata),
      .o_LSU_req_wstrb (req_wstrb),
      .i_LSU_rsp_valid (rsp_valid),
      .i_LSU_rsp_data  (rsp_data),
      .i_LSU_rsp_err   (rsp_err)
   );

   typedef struct {
      logic          st;
      logic [2:0]    f3;
      logic [63:0]   addr;
      logic [63:0]   wdata;
      logic [63:0]   rsp;
      logic          err;
      int            dly;
      logic          xreq;
      logic [63:0]   xaddr;
      logic [7:0]    xwstrb;
      logic [63:0]   xwdata;
      logic          xfault;
      logic [3:0]    xcause;
      logic          xwen;
      logic [63:0]   xrdata;
   } vec_t;

   vec_t vt[17];

   function automatic vec_t mk(
      input logic st, input logic [2:0] f,
      input logic [63:0] a, input logic [63:0] wd,
      input logic [63:0] rs, input logic er, input int dl,
      input logic xr, input logic [63:0] xa,
      input logic [7:0] xs, input logic [63:0] xw,
      input logic xf, input logic [3:0] xc,
      input logic xe, input logic [63:0] xd
   );
      vec_t v;
      v.st = st; v.f3 = f; v.addr = a; v.wdata = wd;
      v.rsp = rs; v.err = er; v.dly = dl;
      v.xreq = xr; v.xaddr = xa; v.xwstrb = xs;
      v.xwdata = xw; v.xfault = xf; v.xcause = xc;
      v.xwen = xe; v.xrdata = xd;
      return v;
   endfunction

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input int i, input vec_t v);
      int n;
      logic seen;
      valid = 1'b1; load = ~v.st; store = v.st;
      f3 = v.f3; addr = v.addr; wdata = v.wdata;
      #1;
      chk($sformatf("v%0d_idle_stall", i), 64'(stall), 64'd1);
      tick();
      valid = 1'b0; load = 1'b0; store = 1'b0;
      seen = 1'b0;
      n = 0;
      while (!done && !req_valid && n < 20) begin
         tick();
         n++;
      end
      if (req_valid) begin
         seen = 1'b1;
         chk($sformatf("v%0d_req_addr", i), req_addr, v.xaddr);
         chk($sformatf("v%0d_wstrb", i), 64'(req_wstrb),
             64'(v.xwstrb));
         chk($sformatf("v%0d_wdata", i), req_wdata, v.xwdata);
         chk($sformatf("v%0d_we", i), 64'(req_we), 64'(v.st));
         for (int k = 0; k < v.dly; k++) begin
            tick();
            chk($sformatf("v%0d_req_hold", i),
                {req_valid, req_wstrb, req_wdata[63:32]},
                {1'b1, v.xwstrb, v.xwdata[63:32]});
         end
         req_ready = 1'b1;
         tick();
         req_ready = 1'b0;
         chk($sformatf("v%0d_rsp_wait", i),
             64'({req_valid, stall, done}), 64'b010);
         rsp_valid = 1'b1; rsp_data = v.rsp; rsp_err = v.err;
         tick();
         rsp_valid = 1'b0; rsp_err = 1'b0; rsp_data = '0;
      end
      chk($sformatf("v%0d_req_seen", i), 64'(seen), 64'(v.xreq));
      chk($sformatf("v%0d_done", i), 64'({done, stall}), 64'b10);
      chk($sformatf("v%0d_fault", i), 64'({fault, cause}),
          64'({v.xfault, v.xcause}));
      chk($sformatf("v%0d_rf_wen", i), 64'(rf_wen), 64'(v.xwen));
      if (v.xwen)
         chk($sformatf("v%0d_rdata", i), rdata, v.xrdata);
      tick();
      chk($sformatf("v%0d_done_pulse", i),
          64'({done, stall}), 64'b00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1; valid = 0; load = 0; store = 0; flush = 0;
      f3 = '0; addr = '0; wdata = '0; req_ready = 0;
      rsp_valid = 0; rsp_data = '0; rsp_err = 0;

      vt[0]  = mk(0, 3'b000, 64'h8000_0003, 0,
                  64'h0000_0000_8000_0000, 0, 0, 1,
                  64'h8000_0000, 8'h00, 64'h0, 0, 0, 1,
                  64'hFFFF_FFFF_FFFF_FF80);
      vt[1]  = mk(1, 3'b001, 64'h8000_0006, 64'hBEEF,
                  0, 0, 2, 1, 64'h8000_0000, 8'hC0,
                  64'hBEEF_0000_0000_0000, 0, 0, 0, 0);
      vt[2]  = mk(0, 3'b010, 64'h8000_0002, 0, 0, 0, 0,
                  0, 0, 0, 0, 1, 4'd4, 0, 0);
      vt[3]  = mk(0, 3'b101, 64'h8000_000A, 0,
                  64'h1122_3344_F00D_5566, 0, 1, 1,
                  64'h8000_0008, 0, 0, 0, 0, 1,
                  64'h0000_0000_0000_F00D);
      vt[4]  = mk(0, 3'b001, 64'h8000_000A, 0,
                  64'h1122_3344_F00D_5566, 0, 0, 1,
                  64'h8000_0008, 0, 0, 0, 0, 1,
                  64'hFFFF_FFFF_FFFF_F00D);
      vt[5]  = mk(0, 3'b010, 64'h8000_0004, 0,
                  64'h8765_4321_0000_0000, 0, 0, 1,
                  64'h8000_0000, 0, 0, 0, 0, 1,
                  64'hFFFF_FFFF_8765_4321);
      vt[6]  = mk(0, 3'b110, 64'h8000_0004, 0,
                  64'h8765_4321_0000_0000, 0, 0, 1,
                  64'h8000_0000, 0, 0, 0, 0, 1,
                  64'h0000_0000_8765_4321);
      vt[7]  = mk(0, 3'b011, 64'h8000_0008, 0,
                  64'hDEAD_BEEF_CAFE_F00D, 0, 0, 1,
                  64'h8000_0008, 0, 0, 0, 0, 1,
                  64'hDEAD_BEEF_CAFE_F00D);
      vt[8]  = mk(1, 3'b010, 64'h8000_0004,
                  64'hAAAA_AAAA_1234_5678, 0, 0, 0, 1,
                  64'h8000_0000, 8'hF0,
                  64'h1234_5678_0000_0000, 0, 0, 0, 0);
      vt[9]  = mk(1, 3'b000, 64'h8000_0005, 64'h5A,
                  0, 0, 0, 1, 64'h8000_0000, 8'h20,
                  64'h0000_5A00_0000_0000, 0, 0, 0, 0);
      vt[10] = mk(1, 3'b011, 64'h8000_0010,
                  64'h0123_4567_89AB_CDEF, 0, 0, 0, 1,
                  64'h8000_0010, 8'hFF,
                  64'h0123_4567_89AB_CDEF, 0, 0, 0, 0);
      vt[11] = mk(1, 3'b010, 64'h8000_0001, 64'h1, 0, 0, 0,
                  0, 0, 0, 0, 1, 4'd6, 0, 0);
      vt[12] = mk(1, 3'b011, 64'h8000_0004, 64'h1, 0, 0, 0,
                  0, 0, 0, 0, 1, 4'd6, 0, 0);
      vt[13] = mk(0, 3'b000, 64'h8000_0000, 0,
                  64'h55, 1, 0, 1, 64'h8000_0000, 0, 0,
                  1, 4'd5, 0, 0);
      vt[14] = mk(1, 3'b001, 64'h8000_0002, 64'h1234,
                  0, 1, 0, 1, 64'h8000_0000, 8'h0C,
                  64'h0000_0000_1234_0000, 1, 4'd7, 0, 0);
      vt[15] = mk(0, 3'b100, 64'h8000_0007, 0,
                  64'hAB00_0000_0000_0000, 0, 0, 1,
                  64'h8000_0000, 0, 0, 0, 0, 1, 64'hAB);
      vt[16] = mk(0, 3'b001, 64'h8000_0003, 0, 0, 0, 0,
                  0, 0, 0, 0, 1, 4'd4, 0, 0);

      tick();
      tick();
      chk("rst_ctl", 64'({stall, done, req_valid, req_we,
                          rf_wen, fault}), 64'd0);
      chk("rst_cause", 64'(cause), 64'd0);
      chk("rst_rdata", rdata, 64'd0);
      chk("rst_bus", req_addr | req_wdata | 64'(req_wstrb),
          64'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 17; i++)
         run_vec(i, vt[i]);

      // ld with no response: fault after TIMEOUT+1 cycles in S_RSP
      valid = 1; load = 1; f3 = 3'b011; addr = 64'h8000_0000;
      tick();
      valid = 0; load = 0;
      chk("to_req", 64'(req_valid), 64'd1);
      req_ready = 1;
      tick();
      req_ready = 0;
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      chk("to_latency", 64'(n), 64'(TO + 1));
      chk("to_fault", 64'({done, fault, cause, rf_wen}),
          64'({1'b1, 1'b1, 4'd5, 1'b0}));
      tick();
      rsp_valid = 1; rsp_data = 64'h1111;
      tick();
      rsp_valid = 0; rsp_data = '0;
      chk("to_stray", 64'({done, stall, req_valid}), 64'd0);
      tick();
      chk("to_stray2", 64'(done), 64'd0);

      // response in the very cycle the counter hits TIMEOUT
      valid = 1; load = 1; f3 = 3'b011; addr = 64'h8000_0018;
      tick();
      valid = 0; load = 0;
      req_ready = 1;
      tick();
      req_ready = 0;
      for (int k = 0; k < TO; k++)
         tick();
      chk("race_wait", 64'({done, stall}), 64'b01);
      rsp_valid = 1; rsp_data = 64'h1357_9BDF_2468_ACE0;
      tick();
      rsp_valid = 0; rsp_data = '0;
      chk("race_done", 64'({done, fault, rf_wen}), 64'b101);
      chk("race_rdata", rdata, 64'h1357_9BDF_2468_ACE0);
      tick();

      // flush while waiting for the response of lhu
      valid = 1; load = 1; f3 = 3'b101; addr = 64'h0200_BFF8;
      tick();
      valid = 0; load = 0;
      chk("fl_addr", req_addr, 64'h0200_BFF8);
      req_ready = 1;
      tick();
      req_ready = 0;
      flush = 1;
      tick();
      flush = 0;
      chk("fl_stall", 64'({stall, done}), 64'b10);
      rsp_valid = 1; rsp_data = 64'h7777;
      tick();
      rsp_valid = 0; rsp_data = '0;
      chk("fl_done", 64'({done, rf_wen, fault}), 64'b100);
      tick();

      // flush during S_REQ of a store: request is not retracted
      valid = 1; store = 1; f3 = 3'b010; addr = 64'h8000_0000;
      wdata = 64'hCAFE;
      tick();
      valid = 0; store = 0;
      flush = 1;
      tick();
      flush = 0;
      chk("flr_hold", 64'({req_valid, req_we, req_wstrb}),
          64'({1'b1, 1'b1, 8'h0F}));
      req_ready = 1;
      tick();
      req_ready = 0;
      rsp_valid = 1; rsp_err = 1;
      tick();
      rsp_valid = 0; rsp_err = 0;
      chk("flr_done", 64'({done, fault, cause}),
          64'({1'b1, 1'b0, 4'd0}));
      tick();

      // flush in S_IDLE blocks the access entirely
      valid = 1; load = 1; flush = 1; f3 = 3'b000;
      addr = 64'h8000_0000;
      #1;
      chk("fli_stall", 64'(stall), 64'd0);
      tick();
      chk("fli_none", 64'({req_valid, done}), 64'd0);
      valid = 0; load = 0; flush = 0;
      tick();
      chk("fli_none2", 64'({req_valid, done, stall}), 64'd0);

      // reset while the request is pending
      valid = 1; store = 1; f3 = 3'b010; addr = 64'h8000_0000;
      tick();
      valid = 0; store = 0;
      chk("rr_req", 64'(req_valid), 64'd1);
      rst = 1;
      tick();
      rst = 0;
      chk("rr_abort", 64'({req_valid, stall, done}), 64'd0);
      tick();
      chk("rr_idle", 64'({req_valid, stall, done}), 64'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
